// File: rtl/seq_counter_pkg.sv
// Shared constants for the programmable sequence counter: default code table
// plus the direction and mode encodings used on DIR and MODE.
package seq_counter_pkg;

    // Default table, entry 0 in the least significant nibble.
    // Entries 0..9 = 4,11,2,0,4,2,10,3,15,1; entries 10..15 = 0.
    localparam logic [15:0][3:0] DEFAULT_SEQ = {
        {6{4'd0}},
        4'd1, 4'd15, 4'd3, 4'd10, 4'd2,
        4'd4, 4'd0,  4'd2, 4'd11, 4'd4
    };

    localparam logic DIR_FWD      = 1'b0;
    localparam logic DIR_BWD      = 1'b1;

    localparam logic MODE_WRAP    = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/seq_table.sv
// N x W code table: async reset to the default sequence, one synchronous
// write port and one combinational read port addressed by the current index.
module seq_table
    import seq_counter_pkg::*;
#(
    parameter int W  = 4,
    parameter int N  = 10,
    parameter int AW = 4
) (
    input  logic          C,
    input  logic          R,
    input  logic          WE,
    input  logic [AW-1:0] WA,
    input  logic [W-1:0]  WD,
    input  logic [AW-1:0] IDX,
    output logic [W-1:0]  Q
);

    logic [W-1:0] mem [N];

    // Table storage: restore defaults on reset, accept in-range writes only.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            for (int i = 0; i < N; i++) begin
                mem[i] <= W'(DEFAULT_SEQ[i]);
            end
        end else if (WE && (int'(WA) < N)) begin
            mem[WA] <= WD;
        end
    end

    // Combinational read so a step and a write landing together show at once.
    always_comb begin
        Q = '0;
        if (int'(IDX) < N) begin
            Q = mem[IDX];
        end
    end

endmodule

// File: rtl/seq_counter_prog.sv
// Programmable arbitrary-sequence counter. Walks an index through a
// rewritable code table, forward or backward, wrapping or one-shot, with a
// runtime length and a jump load. Q is the table entry at the current index.
module seq_counter_prog
    import seq_counter_pkg::*;
#(
    parameter int W  = 4,
    parameter int N  = 10,
    parameter int AW = 4
) (
    input  logic          C,
    input  logic          R,
    input  logic          EN,
    input  logic          DIR,
    input  logic          MODE,
    input  logic [AW-1:0] LEN,
    input  logic          LD,
    input  logic [AW-1:0] LA,
    input  logic          WE,
    input  logic [AW-1:0] WA,
    input  logic [W-1:0]  WD,
    output logic [W-1:0]  Q,
    output logic [AW-1:0] IDX,
    output logic          TC,
    output logic          DONE
);

    localparam logic [AW-1:0] LAST_MAX = AW'(N - 1);

    logic [AW-1:0] last;
    logic [AW-1:0] idx_q;
    logic [AW-1:0] idx_d;
    logic          done_q;
    logic          done_d;
    logic          at_end_fwd;
    logic          at_end_bwd;
    logic          step;

    // Last valid index for the active length; 0 or out-of-range means full table.
    always_comb begin
        last = LAST_MAX;
        if ((LEN != '0) && (int'(LEN) <= N)) begin
            last = LEN - AW'(1);
        end
    end

    // Terminal detection; forward uses >= so a shrunk LEN below IDX still terminates.
    always_comb begin
        at_end_fwd = (idx_q >= last);
        at_end_bwd = (idx_q == '0);
        step       = EN && !done_q;
        TC         = step && ((DIR == DIR_BWD) ? at_end_bwd : at_end_fwd);
    end

    // Next index/DONE: jump load beats stepping, stepping beats hold.
    always_comb begin
        idx_d  = idx_q;
        done_d = done_q;
        if (LD) begin
            idx_d  = (LA > last) ? last : LA;
            done_d = 1'b0;
        end else if (step) begin
            if (DIR == DIR_FWD) begin
                if (at_end_fwd) begin
                    if (MODE == MODE_WRAP) idx_d  = '0;
                    else                   done_d = 1'b1;
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end else begin
                if (at_end_bwd) begin
                    if (MODE == MODE_WRAP) idx_d  = last;
                    else                   done_d = 1'b1;
                end else if (idx_q > last) begin
                    idx_d = last;
                end else begin
                    idx_d = idx_q - AW'(1);
                end
            end
        end
    end

    // Index and DONE registers.
    always_ff @(posedge C or posedge R) begin
        if (R) begin
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            done_q <= done_d;
        end
    end

    assign IDX  = idx_q;
    assign DONE = done_q;

    seq_table #(
        .W  (W),
        .N  (N),
        .AW (AW)
    ) u_table (
        .C   (C),
        .R   (R),
        .WE  (WE),
        .WA  (WA),
        .WD  (WD),
        .IDX (idx_q),
        .Q   (Q)
    );

endmodule
